// File: rtl/led_scan_pkg.sv
// Shared types and sizing helpers for the LED column scan sequencer.
// Imported by the scan controller top level and its frame buffer.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // The dwell/blank counter must hold the larger of the two intervals.
  function automatic int scan_cnt_width(input int dwell, input int blank);
    int longest;
    longest = (dwell > blank) ? dwell : blank;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double buffer for the LED grid: one pending slot fed by the game core and
// the display register that is only replaced on a frame boundary.
module led_frame_buffer
  import led_scan_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] frame_in,
  input  logic         accept,
  input  logic         swap,
  output logic         frame_ready,
  output logic [W-1:0] cells
);

  logic [W-1:0] pending_q, pending_d;
  logic [W-1:0] cells_q, cells_d;
  logic         ready_q, ready_d;

  // Accept needs an empty slot and swap needs a full one, so the two never coincide.
  always_comb begin
    pending_d = pending_q;
    cells_d   = cells_q;
    ready_d   = ready_q;
    if (swap) begin
      cells_d = pending_q;
      ready_d = 1'b1;
    end else if (accept) begin
      pending_d = frame_in;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cells_q   <= '0;
      ready_q   <= 1'b1;
    end else begin
      pending_q <= pending_d;
      cells_q   <= cells_d;
      ready_q   <= ready_d;
    end
  end

  assign frame_ready = ready_q;
  assign cells       = cells_q;

endmodule

// File: rtl/led_scan_controller.sv
// Column scan sequencer for the Conway LED array: steps x through the columns
// with blanking gaps around each dwell and swaps in new frames at the wrap.
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int N            = 8,
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [N*N-1:0]       frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [$clog2(N):0]   x,
  output logic                 ena,
  output logic [N*N-1:0]       cells,
  output logic                 frame_start
);

  localparam int XW = $clog2(N) + 1;
  localparam int CW = scan_cnt_width(DWELL_CYCLES, BLANK_CYCLES);

  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit            NO_BLANK   = (BLANK_CYCLES == 0);

  scan_state_t   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ena_q, ena_d;
  logic          frame_start_q, frame_start_d;

  logic          wrap;
  logic          accept;
  logic          swap;

  // Next-state logic; dropping run wins over everything and parks the scan at column 0.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    cnt_d         = cnt_q;
    ena_d         = ena_q;
    frame_start_d = 1'b0;
    wrap          = 1'b0;

    if (!run) begin
      state_d = IDLE;
      x_d     = '0;
      cnt_d   = '0;
      ena_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          x_d           = '0;
          cnt_d         = '0;
          frame_start_d = 1'b1;
          if (NO_BLANK) begin
            state_d = DRIVE;
            ena_d   = 1'b1;
          end else begin
            state_d = BLANK;
            ena_d   = 1'b0;
          end
        end

        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            ena_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            // x moves on the same edge that ena falls, so the driver never sees it change while lit.
            if (x_q == X_LAST) begin
              x_d           = '0;
              wrap          = 1'b1;
              frame_start_d = 1'b1;
            end else begin
              x_d = x_q + XW'(1);
            end
            if (NO_BLANK) begin
              state_d = DRIVE;
              ena_d   = 1'b1;
            end else begin
              state_d = BLANK;
              ena_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        default: begin
          state_d = IDLE;
          x_d     = '0;
          cnt_d   = '0;
          ena_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      cnt_q         <= '0;
      ena_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      cnt_q         <= cnt_d;
      ena_q         <= ena_d;
      frame_start_q <= frame_start_d;
    end
  end

  // An idle display refreshes as soon as a frame lands; a running one waits for the wrap.
  assign accept = frame_valid && frame_ready;
  assign swap   = !frame_ready && ((state_q == IDLE) || wrap);

  led_frame_buffer #(
    .W(N * N)
  ) u_frame_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_in    (frame_in),
    .accept      (accept),
    .swap        (swap),
    .frame_ready (frame_ready),
    .cells       (cells)
  );

  assign x           = x_q;
  assign ena         = ena_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Randomized scoreboard bench for led_scan_controller (N=8, dwell 4, blank 1)
// against a cycle-count reference model of the scan and double buffer.
module tb_led_scan_controller;

  localparam int N      = 8;
  localparam int DWELL  = 4;
  localparam int BLANKC = 1;
  localparam int COLP   = DWELL + BLANKC;
  localparam int PERIOD = N * COLP;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [63:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [3:0]  x;
  logic        ena;
  logic [63:0] cells;
  logic        frame_start;

  typedef struct packed {
    logic [3:0]  x;
    logic        ena;
    logic        fs;
    logic        ready;
    logic [63:0] cells;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  bit          model_running;
  int          model_p;
  bit          model_pend_full;
  logic [63:0] model_pend;
  logic [63:0] model_disp;
  bit          model_acc;

  led_scan_controller #(
    .N            (N),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANKC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .x           (x),
    .ena         (ena),
    .cells       (cells),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Reference model: position in the frame is just cycles since run rose.
  initial begin
    exp_t e;
    bit   sw;
    int   off;
    model_running   = 0;
    model_p         = 0;
    model_pend_full = 0;
    model_pend      = '0;
    model_disp      = '0;
    model_acc       = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_running   = 0;
        model_p         = 0;
        model_pend_full = 0;
        model_pend      = '0;
        model_disp      = '0;
        model_acc       = 0;
        e = '{x: 4'd0, ena: 1'b0, fs: 1'b0, ready: 1'b1, cells: 64'd0};
      end else begin
        model_acc = frame_valid && !model_pend_full;
        if (run) begin
          model_p       = model_running ? model_p + 1 : 0;
          model_running = 1;
          off           = model_p % COLP;
          e.x           = 4'((model_p / COLP) % N);
          e.ena         = (off >= BLANKC);
          e.fs          = ((model_p % PERIOD) == 0);
          sw            = model_pend_full && ((model_p % PERIOD) == 0);
        end else begin
          sw            = model_pend_full && !model_running;
          model_running = 0;
          e.x           = 4'd0;
          e.ena         = 1'b0;
          e.fs          = 1'b0;
        end
        if (sw) begin
          model_disp      = model_pend;
          model_pend_full = 0;
        end
        if (model_acc) begin
          model_pend      = frame_in;
          model_pend_full = 1;
        end
        e.ready = !model_pend_full;
        e.cells = model_disp;
      end
      sb_q.push_back(e);
    end
  end

  // Monitor: one expected entry per active edge, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checkOutput("scoreboard_empty", 64'd0, 64'd1);
      end else begin
        e = sb_q.pop_front();
        checkOutput("x",           64'(x),           64'(e.x));
        checkOutput("ena",         64'(ena),         64'(e.ena));
        checkOutput("frame_start", 64'(frame_start), 64'(e.fs));
        checkOutput("frame_ready", 64'(frame_ready), 64'(e.ready));
        checkOutput("cells",       cells,            e.cells);
      end
    end
  end

  // mode: 0 run low, 1 run high, 2 run random with rare drops.
  task automatic applyStimulus(input int cycles, input int mode, input int drop_per_mille, input int valid_pct);
    repeat (cycles) begin
      @(negedge clk);
      case (mode)
        0: run = 1'b0;
        1: run = 1'b1;
        default: begin
          if (run) run = !($urandom_range(999) < drop_per_mille);
          else     run = ($urandom_range(99) < 20);
        end
      endcase
      if (!frame_valid || model_acc) begin
        frame_valid = ($urandom_range(99) < valid_pct);
        frame_in    = {$urandom, $urandom};
      end
    end
  endtask

  initial begin
    bit seen;
    rst_n       = 1'b0;
    run         = 1'b0;
    frame_valid = 1'b0;
    frame_in    = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(100, 1, 0, 0);

    @(negedge clk);
    run         = 1'b0;
    frame_valid = 1'b1;
    frame_in    = 64'h00000000_00000018;
    applyStimulus(8, 0, 0, 0);

    applyStimulus(600, 1, 0, 40);
    applyStimulus(2000, 2, 20, 50);

    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ena) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput("wait_drive_timeout", 64'd0, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_ena",   64'(ena),         64'd0);
    checkOutput("async_x",     64'(x),           64'd0);
    checkOutput("async_cells", cells,            64'd0);
    checkOutput("async_ready", 64'(frame_ready), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(300, 2, 20, 50);
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
